// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, FETCH/HOLD/DISCARD fetch FSM and the IF/ID pipeline register.
// Defining IF_PERF_CNT_EN adds the fetch_count output, which counts valid IF/ID loads.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_select,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busywait,
    output logic [31:0] instruction_out,
    output logic [31:0] PC_out,
    output logic        valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcout_q, pcout_d;
    logic        valid_q, valid_d;
    logic [31:0] target;

    assign target = branch_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= 32'h0;
            buf_q   <= 32'h0;
            instr_q <= NOP_INSTR;
            pcout_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
        end
    end

    // A redirect always flushes IF/ID, even when downstream is stalled.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
        case (state_q)
            FETCH: begin
                if (pc_select) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (imem_busywait) begin
                        pend_d  = target;
                        state_d = DISCARD;
                    end else begin
                        pc_d = target;
                    end
                end else if (imem_busywait) begin
                    if (!stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (stall) begin
                    buf_d   = imem_rdata;
                    state_d = HOLD;
                end else begin
                    instr_d = imem_rdata;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                end
            end
            HOLD: begin
                if (pc_select) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = FETCH;
                end else if (!stall) begin
                    instr_d = buf_q;
                    pcout_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                // The in-flight word belongs to the abandoned path; keep imem_addr steady until it completes.
                if (pc_select) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (imem_busywait) begin
                        pend_d = target;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end else begin
                    if (!stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                    if (!imem_busywait) begin
                        pc_d    = pend_q;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    assign imem_addr       = pc_q;
    assign imem_read       = (state_q != HOLD);
    assign instruction_out = instr_q;
    assign PC_out          = pcout_q;
    assign valid_out       = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_q;
    logic        load_valid;

    assign load_valid = !pc_select && !stall &&
                        ((state_q == FETCH && !imem_busywait) || state_q == HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 32'h0;
        end else if (load_valid) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [31:0] tgt;
    logic        st;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] instruction_out;
    logic [31:0] PC_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: a buffered word awaiting release, and a redirect waiting on a busy fetch.
    logic [31:0] m_pc;
    bit          m_have_buf;
    logic [31:0] m_buf;
    bit          m_redir;
    logic [31:0] m_pend;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;
    bit          m_valid;
    logic [31:0] m_cnt;

    if_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk            (clk),
        .reset          (rst),
        .pc_select      (sel),
        .branch_target  (tgt),
        .stall          (st),
        .imem_addr      (imem_addr),
        .imem_read      (imem_read),
        .imem_rdata     (rdata),
        .imem_busywait  (busy),
        .instruction_out(instruction_out),
        .PC_out         (PC_out),
        .valid_out      (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update();
        logic [31:0] aligned;
        aligned = tgt & 32'hFFFF_FFFC;
        if (rst) begin
            m_pc = RESET_PC; m_have_buf = 0; m_buf = 0; m_redir = 0; m_pend = 0;
            m_instr = NOP_INSTR; m_pcout = 0; m_valid = 0; m_cnt = 0;
        end else if (sel) begin
            m_instr = NOP_INSTR; m_valid = 0;
            if (m_have_buf || !busy) begin
                m_pc = aligned; m_have_buf = 0; m_redir = 0;
            end else begin
                m_pend = aligned; m_redir = 1;
            end
        end else if (m_have_buf) begin
            if (!st) begin
                m_instr = m_buf; m_pcout = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
                m_pc = m_pc + 4; m_have_buf = 0;
            end
        end else if (m_redir) begin
            if (!st) begin m_instr = NOP_INSTR; m_valid = 0; end
            if (!busy) begin m_pc = m_pend; m_redir = 0; end
        end else if (busy) begin
            if (!st) begin m_instr = NOP_INSTR; m_valid = 0; end
        end else if (st) begin
            m_buf = rdata; m_have_buf = 1;
        end else begin
            m_instr = rdata; m_pcout = m_pc; m_valid = 1; m_cnt = m_cnt + 1;
            m_pc = m_pc + 4;
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge) and return at the next falling edge.
    task automatic step(input logic r, input logic s, input logic [31:0] t,
                        input logic stl, input logic b, input logic [31:0] d);
        rst = r; sel = s; tgt = t; st = stl; busy = b; rdata = d;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1; sel = 1; tgt = 32'h55; st = 1; busy = 1; rdata = 32'hFFFF_FFFF;
        @(posedge clk); model_update(); @(negedge clk);
        step(1, 1, 32'h77, 1, 1, 0);
        rst = 0; sel = 0; st = 0; busy = 0;
        vectors++;
        if (imem_addr !== RESET_PC) begin
            miscompares++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC);
        end
        vectors++;
        if (imem_read !== 1'b1) begin
            miscompares++; $display("FAIL reset_read got %b want 1", imem_read);
        end
        vectors++;
        if (instruction_out !== NOP_INSTR || PC_out !== 32'h0 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ifid got %h/%h/%b want %h/0/0", instruction_out, PC_out, valid_out, NOP_INSTR);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] w;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w = 32'h1000_0000 + i;
            step(0, 0, 0, 0, 0, w);
            vectors++;
            if (PC_out !== 32'(i * 4) || valid_out !== 1'b1 || instruction_out !== w) begin
                miscompares++;
                $display("FAIL zero_wait[%0d] got pc=%h v=%b i=%h want pc=%h v=1 i=%h",
                         i, PC_out, valid_out, instruction_out, 32'(i * 4), w);
            end
        end
    endtask

    task automatic test_busywait();
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 32'hA0 + i);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 1, 32'hBAD0_0000);
            vectors++;
            if (imem_addr !== 32'h10 || valid_out !== 1'b0 || instruction_out !== NOP_INSTR) begin
                miscompares++;
                $display("FAIL busywait_bubble[%0d] got a=%h v=%b i=%h want a=10 v=0 i=%h",
                         i, imem_addr, valid_out, instruction_out, NOP_INSTR);
            end
        end
        step(0, 0, 0, 0, 0, 32'hC0DE_0010);
        vectors++;
        if (PC_out !== 32'h10 || valid_out !== 1'b1 || instruction_out !== 32'hC0DE_0010) begin
            miscompares++;
            $display("FAIL busywait_release got pc=%h v=%b i=%h want pc=10 v=1 i=c0de0010",
                     PC_out, valid_out, instruction_out);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        step(0, 0, 0, 0, 0, 32'h1111_1111);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0, (i == 0) ? 32'h00A0_0093 : 32'hEEEE_0000 + i);
            vectors++;
            if (PC_out !== 32'h0 || instruction_out !== 32'h1111_1111 || valid_out !== 1'b1 ||
                imem_read !== 1'b0 || imem_addr !== 32'h4) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] got pc=%h i=%h v=%b rd=%b a=%h want 0/11111111/1/0/4",
                         i, PC_out, instruction_out, valid_out, imem_read, imem_addr);
            end
        end
        step(0, 0, 0, 0, 0, 32'h2222_2222);
        vectors++;
        if (instruction_out !== 32'h00A0_0093 || PC_out !== 32'h4 || valid_out !== 1'b1 ||
            imem_addr !== 32'h8 || imem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release got i=%h pc=%h v=%b a=%h rd=%b want 00a00093/4/1/8/1",
                     instruction_out, PC_out, valid_out, imem_addr, imem_read);
        end
    endtask

    task automatic test_redirect_discard();
        do_reset();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 32'h300 + i);
        step(0, 1, 32'h40, 0, 1, 32'hDEAD_0020);
        vectors++;
        if (imem_addr !== 32'h20 || imem_read !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL discard_enter got a=%h rd=%b v=%b want 20/1/0", imem_addr, imem_read, valid_out);
        end
        step(0, 0, 0, 0, 0, 32'hDEAD_BEEF);
        vectors++;
        if (imem_addr !== 32'h40 || valid_out !== 1'b0 || instruction_out !== NOP_INSTR) begin
            miscompares++;
            $display("FAIL discard_drop got a=%h v=%b i=%h want 40/0/%h", imem_addr, valid_out, instruction_out, NOP_INSTR);
        end
        step(0, 0, 0, 0, 0, 32'h1234_5678);
        vectors++;
        if (PC_out !== 32'h40 || instruction_out !== 32'h1234_5678 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL discard_target got pc=%h i=%h v=%b want 40/12345678/1", PC_out, instruction_out, valid_out);
        end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        step(0, 0, 0, 0, 0, 32'h3333_3333);
        step(0, 1, 32'h83, 1, 0, 32'h4444_4444);
        vectors++;
        if (valid_out !== 1'b0 || instruction_out !== NOP_INSTR || imem_addr !== 32'h80 || imem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_over_stall got v=%b i=%h a=%h rd=%b want 0/%h/80/1",
                     valid_out, instruction_out, imem_addr, imem_read, NOP_INSTR);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        step(0, 1, 32'hFFFF_FFFE, 0, 0, 0);
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            miscompares++; $display("FAIL wrap_target got %h want fffffffc", imem_addr);
        end
        step(0, 0, 0, 0, 0, 32'h5555_5555);
        vectors++;
        if (PC_out !== 32'hFFFF_FFFC || imem_addr !== 32'h0 || valid_out !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_next got pc=%h a=%h v=%b want fffffffc/0/1", PC_out, imem_addr, valid_out);
        end
    endtask

    task automatic test_discard_retarget();
        do_reset();
        step(0, 1, 32'h100, 0, 1, 0);
        step(0, 1, 32'h200, 0, 1, 0);
        vectors++;
        if (imem_addr !== RESET_PC || imem_read !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++;
            $display("FAIL retarget_hold got a=%h rd=%b v=%b want %h/1/0", imem_addr, imem_read, valid_out, RESET_PC);
        end
        step(0, 0, 0, 0, 0, 32'h6666_6666);
        vectors++;
        if (imem_addr !== 32'h200) begin
            miscompares++; $display("FAIL retarget_last got a=%h want 200", imem_addr);
        end
    endtask

    task automatic test_reset_override();
        do_reset();
        step(0, 0, 0, 0, 0, 32'h7777_7777);
        step(0, 0, 0, 1, 0, 32'h8888_8888);
        step(1, 1, 32'h300, 1, 1, 32'h9999_9999);
        vectors++;
        if (imem_addr !== RESET_PC || imem_read !== 1'b1 || valid_out !== 1'b0 ||
            instruction_out !== NOP_INSTR || PC_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_override got a=%h rd=%b v=%b i=%h pc=%h",
                     imem_addr, imem_read, valid_out, instruction_out, PC_out);
        end
        rst = 0;
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf_count();
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'hF0 + i);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 32'hF8 + i);
        vectors++;
        if (fetch_count !== 32'd5) begin
            miscompares++; $display("FAIL perf_count got %0d want 5", fetch_count);
        end
        step(1, 0, 0, 0, 0, 0);
        vectors++;
        if (fetch_count !== 32'd0) begin
            miscompares++; $display("FAIL perf_count_reset got %0d want 0", fetch_count);
        end
    endtask
`endif

    task automatic test_random();
        logic r, s, stl, b;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 7) == 0);
            stl = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 2) == 0);
            step(r, s, $urandom, stl, b, $urandom);
            vectors++;
            if (imem_addr !== m_pc || imem_read !== !m_have_buf) begin
                miscompares++;
                $display("FAIL random_imem[%0d] got a=%h rd=%b want a=%h rd=%b",
                         n, imem_addr, imem_read, m_pc, !m_have_buf);
            end
            vectors++;
            if (instruction_out !== m_instr || PC_out !== m_pcout || valid_out !== m_valid) begin
                miscompares++;
                $display("FAIL random_ifid[%0d] got i=%h pc=%h v=%b want i=%h pc=%h v=%b",
                         n, instruction_out, PC_out, valid_out, m_instr, m_pcout, m_valid);
            end
`ifdef IF_PERF_CNT_EN
            vectors++;
            if (fetch_count !== m_cnt) begin
                miscompares++;
                $display("FAIL random_count[%0d] got %0d want %0d", n, fetch_count, m_cnt);
            end
`endif
        end
    endtask

    initial begin
        rst = 1; sel = 0; tgt = 0; st = 0; busy = 0; rdata = 0;
        test_reset();
        test_zero_wait();
        test_busywait();
        test_stall_hold();
        test_redirect_discard();
        test_flush_over_stall();
        test_pc_wrap();
        test_discard_retarget();
        test_reset_override();
`ifdef IF_PERF_CNT_EN
        test_perf_count();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 Parameter RESET_PC, default 32'h0000_0000; PC loaded on reset.
- REQ-002 Parameter NOP_INSTR, default 32'h0000_0013; instruction emitted as a bubble.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset.
- REQ-005 pc_select  input  1  redirect request from EX (taken branch or jump).
- REQ-006 branch_target  input  32  redirect address from EX; bits [1:0] are ignored and treated as 0.
- REQ-007 stall  input  1  downstream busywait; holds the IF/ID register when high.
- REQ-008 imem_addr  output  32  instruction memory address.
- REQ-009 imem_read  output  1  instruction memory read request.
- REQ-010 imem_rdata  input  32  instruction word; valid in a cycle where imem_read=1 and imem_busywait=0.
- REQ-011 imem_busywait  input  1  memory not ready; imem_addr must stay stable while it is high.
- REQ-012 instruction_out  output  32  IF/ID registered instruction.
- REQ-013 PC_out  output  32  IF/ID registered address of instruction_out.
- REQ-014 valid_out  output  1  IF/ID holds a real instruction (0 = bubble).

Function
- REQ-015 FSM states: FETCH, HOLD, DISCARD.
- REQ-016 In FETCH and DISCARD: imem_read=1 and imem_addr=pc. In HOLD: imem_read=0 and imem_addr=pc.
- REQ-017 FETCH accept (busywait=0, pc_select=0, stall=0): IF/ID <= {imem_rdata, pc, valid=1}; pc <= pc+4; stay in FETCH.
- REQ-018 FETCH accept with stall=1: imem_rdata goes to the hold buffer; IF/ID unchanged; go to HOLD.
- REQ-019 FETCH with busywait=1, stall=0, pc_select=0: IF/ID <= bubble (NOP_INSTR, valid=0).
- REQ-020 HOLD with stall=0: IF/ID <= {buffer, pc, valid=1}; pc <= pc+4; go to FETCH.
- REQ-021 pc_select=1 with busywait=0 or in HOLD: drop the fetched/buffered word; pc <= target; go to FETCH.
- REQ-022 pc_select=1 in FETCH with busywait=1: latch target into pending_pc; go to DISCARD.
- REQ-023 DISCARD: when busywait=0, drop rdata, pc <= pending_pc, go to FETCH; while busywait=1, stay in DISCARD with imem_addr unchanged.
- REQ-024 Any cycle with pc_select=1: IF/ID <= bubble; flush takes priority over stall.
- REQ-025 pc_select=1 while in DISCARD: pending_pc is overwritten (last redirect wins).
- REQ-026 stall=1 and pc_select=0: IF/ID holds its value in every state.
- REQ-027 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- REQ-028 Fetch-to-IF/ID latency: one cycle after the accepting edge with zero wait states; sustained throughput of 1 instruction/cycle.

Reset
- REQ-029 reset: pc=RESET_PC, state=FETCH, instruction_out=NOP_INSTR, PC_out=0, valid_out=0, buffer=0, pending_pc=0.
- REQ-030 reset overrides pc_select, stall and any outstanding request; imem_read=1 at RESET_PC in the first cycle after reset.

Configuration
- REQ-031 Macro IF_PERF_CNT_EN defined: adds output fetch_count (32-bit); it increments on each IF/ID load with valid=1, wraps, and resets to 0.
- REQ-032 Macro IF_PERF_CNT_EN undefined: fetch_count port and counter are absent; all other behaviour is identical.

Verification
- REQ-033 Reset then 3 zero-wait fetches from RESET_PC=0 -> PC_out 0,4,8 on consecutive cycles, valid_out=1.
- REQ-034 imem_busywait high for 2 cycles at pc=0x10 -> imem_addr stays 0x10, 2 bubbles, then PC_out=0x10.
- REQ-035 stall=1 for 3 cycles when word 0x00A00093 is accepted -> IF/ID unchanged, state HOLD, imem_read=0; after release, instruction_out=0x00A00093.
- REQ-036 pc_select=1 with target 0x40 while busywait=1 at 0x20 -> DISCARD, 0x20 data dropped, next imem_addr=0x40, IF/ID bubble.
- REQ-037 pc_select and stall high in the same cycle -> valid_out=0 next cycle, pc=target.
- REQ-038 Under IF_PERF_CNT_EN: 5 valid loads plus 2 bubbles -> fetch_count=5; reset -> 0.
